kbd_event_ctrl: RTL

Parametrised PS/2 keyboard front end that turns raw PS/2 frames into decoded key events: {extended, break, repeat, scan code}. Receives and checks 11-bit frames, parses E0/F0 prefixes, filters or flags typematic repeats, and buffers events in a FIFO with a valid/ready interface. Sits between the PS/2 pins and any consumer such as the display, count or ASCII logic. Replaces the single-byte make/break tracker.

---
 rtl/kbd_pkg.sv | 32 +++
 rtl/ps2_frame_rx.sv | 82 ++++++++
 rtl/kbd_event_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared types and constants for the PS/2 keyboard event front end
//
// Purpose: event record, parser state encoding, prefix scan codes and the
// frame parity helper used by ps2_frame_rx and kbd_event_ctrl.

package kbd_pkg;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic       rpt;
    logic [7:0] code;
  } kbd_event_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0
  } parse_state_t;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_ERR0 = 8'h00;
  localparam logic [7:0] SC_ERR1 = 8'hFF;

  // Data byte plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] data_and_parity);
    return ^data_and_parity;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 11-bit frame receiver with sync, checks and timeout
//
// Purpose: synchronise the raw PS/2 pins, shift in one bit per falling edge
// of ps2_clk, and validate start/parity/stop once all 11 bits are in.
// Ports:
//   clk, rst           - system clock, async active-high reset
//   ps2_clk, ps2_data  - raw asynchronous PS/2 pins
//   byte_valid         - 1-cycle pulse, data_byte holds a good byte
//   data_byte          - received data byte
//   frame_err          - 1-cycle pulse, frame had bad start, parity or stop

module ps2_frame_rx
  import kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] data_byte,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    clk_s;
  logic [2:0]    data_s;
  logic          clk_prev;
  logic [3:0]    bit_idx;
  logic [9:0]    shift;
  logic [TW-1:0] tmo_cnt;
  logic          fall;

  assign fall = clk_prev & ~clk_s[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s      <= 3'b111;
      data_s     <= 3'b111;
      clk_prev   <= 1'b1;
      bit_idx    <= 4'd0;
      shift      <= 10'd0;
      tmo_cnt    <= '0;
      byte_valid <= 1'b0;
      data_byte  <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      clk_s      <= {clk_s[1:0], ps2_clk};
      data_s     <= {data_s[1:0], ps2_data};
      clk_prev   <= clk_s[2];
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        if (bit_idx == 4'd10) begin
          // shift[0] = start, shift[8:1] = data, shift[9] = parity; current bit = stop
          bit_idx <= 4'd0;
          if (!shift[0] && odd_parity_ok(shift[9:1]) && data_s[2]) begin
            byte_valid <= 1'b1;
            data_byte  <= shift[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          shift   <= {data_s[2], shift[9:1]};
          bit_idx <= bit_idx + 4'd1;
        end
      end else if (bit_idx != 4'd0) begin
        // Only a partial frame can time out; an idle line never counts.
        if (tmo_cnt == TW'(TIMEOUT_CYC)) begin
          bit_idx <= 4'd0;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/kbd_event_ctrl.sv
// rtl/kbd_event_ctrl.sv - PS/2 keyboard event controller: prefix parser, repeat tracker, event FIFO
//
// Purpose: decode PS/2 scan bytes into {ext, break, repeat, code} events and
// buffer them for a valid/ready consumer.
// Ports:
//   clk, rst            - system clock, async active-high reset
//   ps2_clk, ps2_data   - raw PS/2 pins
//   ev_valid/ev_ready   - show-ahead event FIFO handshake
//   ev_code/ev_ext/ev_break/ev_repeat - head event fields
//   press_count         - non-repeat make events (wraps)
//   err_count           - rejected frames (saturates)
//   overflow            - sticky, an event was dropped on a full FIFO
//   clr_status          - clears overflow and err_count

module kbd_event_ctrl
  import kbd_pkg::*;
#(
  parameter int          FIFO_DEPTH    = 8,
  parameter int          COUNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC   = 50000,
  parameter bit          REPEAT_FILTER = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [7:0]         ev_code,
  output logic               ev_ext,
  output logic               ev_break,
  output logic               ev_repeat,
  output logic [COUNT_W-1:0] press_count,
  output logic [COUNT_W-1:0] err_count,
  output logic               overflow,
  input  logic               clr_status
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic         byte_valid;
  logic [7:0]   rx_byte;
  logic         frame_err;

  ps2_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .data_byte  (rx_byte),
    .frame_err  (frame_err)
  );

  // ---------------- prefix decode ----------------
  parse_state_t state, next_state;
  logic         emit, emit_brk, emit_ext;

  always_comb begin
    next_state = state;
    emit       = 1'b0;
    emit_brk   = 1'b0;
    emit_ext   = 1'b0;
    if (byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_byte == SC_EXT)                             next_state = ST_GOT_E0;
          else if (rx_byte == SC_BRK)                        next_state = ST_GOT_F0;
          else if (rx_byte != SC_ERR0 && rx_byte != SC_ERR1) emit = 1'b1;
        end
        ST_GOT_E0: begin
          if (rx_byte == SC_BRK)      next_state = ST_GOT_E0F0;
          else if (rx_byte != SC_EXT) begin
            emit       = 1'b1;
            emit_ext   = 1'b1;
            next_state = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          emit       = 1'b1;
          emit_brk   = 1'b1;
          next_state = ST_IDLE;
        end
        default: begin
          emit       = 1'b1;
          emit_brk   = 1'b1;
          emit_ext   = 1'b1;
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------- parser state, repeat tracking, push register ----------------
  logic [8:0]  held_key;
  logic        held_valid;
  logic        key_match;
  logic        push;
  kbd_event_t  push_ev;

  assign key_match = held_valid && (held_key == {emit_ext, rx_byte});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      held_key    <= 9'd0;
      held_valid  <= 1'b0;
      press_count <= '0;
      push        <= 1'b0;
      push_ev     <= '0;
    end else begin
      state <= next_state;
      push  <= 1'b0;
      if (emit) begin
        if (emit_brk) begin
          push    <= 1'b1;
          push_ev <= '{ext: emit_ext, brk: 1'b1, rpt: 1'b0, code: rx_byte};
          if (key_match) held_valid <= 1'b0;
        end else if (key_match) begin
          // Typematic repeat: never counted, optionally forwarded
          if (!REPEAT_FILTER) begin
            push    <= 1'b1;
            push_ev <= '{ext: emit_ext, brk: 1'b0, rpt: 1'b1, code: rx_byte};
          end
        end else begin
          held_key    <= {emit_ext, rx_byte};
          held_valid  <= 1'b1;
          press_count <= press_count + COUNT_W'(1);
          push        <= 1'b1;
          push_ev     <= '{ext: emit_ext, brk: 1'b0, rpt: 1'b0, code: rx_byte};
        end
      end
    end
  end

  // ---------------- event FIFO ----------------
  kbd_event_t  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, do_write;
  kbd_event_t    head_ev;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign pop      = ev_valid & ev_ready;
  assign do_write = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= push_ev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      case ({do_write, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign ev_valid  = (count != '0);
  assign head_ev   = mem[rd_ptr];
  assign ev_code   = ev_valid ? head_ev.code : 8'h00;
  assign ev_ext    = ev_valid & head_ev.ext;
  assign ev_break  = ev_valid & head_ev.brk;
  assign ev_repeat = ev_valid & head_ev.rpt;

  // ---------------- status ----------------
  // A new drop or error in the clear cycle takes priority over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_status)      overflow <= 1'b0;
      if (frame_err) begin
        if (err_count != '1) err_count <= err_count + COUNT_W'(1);
      end else if (clr_status) begin
        err_count <= '0;
      end
    end
  end

endmodule
